instr_prefetch_buffer: RTL and testbench



---
 rtl/instr_prefetch_buffer.sv | 247 ++++++++++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: assembles 32-bit instructions from two 16-bit reads into a small FIFO.
// Optional fetch/discard statistics counters are built when PREFETCH_STATS_EN is defined.
module instr_prefetch_buffer #(
  parameter int              ADDR_W   = 25,
  parameter int              PC_W     = 24,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rd_ack,
  input  logic               mem_rd_valid,
  input  logic [15:0]        mem_rd_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]        stat_fetched,
  output logic [15:0]        stat_discarded
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_LO  = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_REQ_HI  = 3'd3,
    ST_WAIT_HI = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

  state_e              state_r;
  logic [PC_W-1:0]     fetch_pc_r;
  logic [15:0]         lo_half_r;
  logic                drain_pend_r;
  logic                mem_rd_req_r;
  logic [ADDR_W-1:0]   mem_addr_r;

  logic [INSTR_W-1:0]  data_mem_r [DEPTH];
  logic [PC_W-1:0]     pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                instr_valid_r;
  logic [INSTR_W-1:0]  instr_data_r;
  logic [PC_W-1:0]     instr_pc_r;

  logic                push_s;
  logic                pop_s;
  logic [INSTR_W-1:0]  push_data_s;
  logic [CNT_W-1:0]    remain_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic [PTR_W-1:0]    rd_ptr_nxt_s;
  logic [INSTR_W-1:0]  head_data_s;
  logic [PC_W-1:0]     head_pc_s;

  function automatic logic [ADDR_W-1:0] half_addr(input logic [PC_W-1:0] pc, input logic hi);
    logic [PC_W:0] full;
    full = {pc, hi};
    return ADDR_W'(full);
  endfunction

  assign mem_rd_req  = mem_rd_req_r;
  assign mem_addr    = mem_addr_r;
  assign instr_valid = instr_valid_r;
  assign instr_data  = instr_data_r;
  assign instr_pc    = instr_pc_r;

  // FIFO push/pop decisions and the head value to register for the next cycle
  always_comb begin
    pop_s        = instr_valid_r & instr_ready & ~redirect_valid;
    push_s       = (state_r == ST_WAIT_HI) & mem_rd_valid & ~redirect_valid;
    push_data_s  = {mem_rd_data, lo_half_r};
    remain_s     = pop_s ? (count_r - CNT_W'(1)) : count_r;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    if (redirect_valid) begin
      count_nxt_s = CNT_ZERO;
    end else if (push_s) begin
      count_nxt_s = remain_s + CNT_W'(1);
    end else begin
      count_nxt_s = remain_s;
    end
    // An entry pushed into an otherwise empty queue bypasses storage to reach the head
    if (count_nxt_s == CNT_ZERO) begin
      head_data_s = instr_data_r;
      head_pc_s   = instr_pc_r;
    end else if (remain_s == CNT_ZERO) begin
      head_data_s = push_data_s;
      head_pc_s   = fetch_pc_r;
    end else begin
      head_data_s = data_mem_r[rd_ptr_nxt_s];
      head_pc_s   = pc_mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers and registered head
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      count_r       <= CNT_ZERO;
      instr_valid_r <= 1'b0;
      instr_data_r  <= {INSTR_W{1'b0}};
      instr_pc_r    <= {PC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_r[i] <= {INSTR_W{1'b0}};
        pc_mem_r[i]   <= {PC_W{1'b0}};
      end
    end else begin
      if (redirect_valid) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          data_mem_r[wr_ptr_r] <= push_data_s;
          pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
          wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
        end
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      count_r       <= count_nxt_s;
      instr_valid_r <= (count_nxt_s != CNT_ZERO);
      instr_data_r  <= head_data_s;
      instr_pc_r    <= head_pc_s;
    end
  end

  // Fetch sequencer: two halfword reads per instruction, with redirect draining
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      fetch_pc_r   <= RESET_PC;
      lo_half_r    <= 16'h0000;
      drain_pend_r <= 1'b0;
      mem_rd_req_r <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
    end else begin
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + PC_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (!redirect_valid && (count_r < DEPTH_C)) begin
            state_r      <= ST_REQ_LO;
            mem_rd_req_r <= 1'b1;
            mem_addr_r   <= half_addr(fetch_pc_r, 1'b0);
          end
        end
        ST_REQ_LO, ST_REQ_HI: begin
          // A redirect cannot withdraw a posted request; remember it and drain after ack
          if (mem_rd_ack) begin
            mem_rd_req_r <= 1'b0;
            drain_pend_r <= 1'b0;
            if (redirect_valid || drain_pend_r) begin
              state_r <= ST_DRAIN;
            end else if (state_r == ST_REQ_LO) begin
              state_r <= ST_WAIT_LO;
            end else begin
              state_r <= ST_WAIT_HI;
            end
          end else if (redirect_valid) begin
            drain_pend_r <= 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (mem_rd_valid) begin
            if (redirect_valid) begin
              state_r <= ST_IDLE;
            end else begin
              lo_half_r    <= mem_rd_data;
              state_r      <= ST_REQ_HI;
              mem_rd_req_r <= 1'b1;
              mem_addr_r   <= half_addr(fetch_pc_r, 1'b1);
            end
          end else if (redirect_valid) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_WAIT_HI: begin
          if (mem_rd_valid) begin
            state_r <= ST_IDLE;
          end else if (redirect_valid) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_rd_valid) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_rd_req_r <= 1'b0;
          drain_pend_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PREFETCH_STATS_EN
  logic        inflight_s;
  logic [16:0] disc_sum_s;
  logic [15:0] stat_fetched_r;
  logic [15:0] stat_discarded_r;

  assign stat_fetched   = stat_fetched_r;
  assign stat_discarded = stat_discarded_r;

  // Count an in-flight instruction only once, even if several redirects hit its drain
  always_comb begin
    inflight_s = redirect_valid & ~drain_pend_r &
                 ((state_r == ST_REQ_LO) | (state_r == ST_WAIT_LO) |
                  (state_r == ST_REQ_HI) | (state_r == ST_WAIT_HI));
    disc_sum_s = {1'b0, stat_discarded_r} + 17'(count_r) + 17'(inflight_s);
  end

  // Saturating statistics counters
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched_r   <= 16'h0000;
      stat_discarded_r <= 16'h0000;
    end else begin
      if (push_s && (stat_fetched_r != 16'hFFFF)) begin
        stat_fetched_r <= stat_fetched_r + 16'h0001;
      end
      if (redirect_valid) begin
        stat_discarded_r <= (disc_sum_s > 17'h0FFFF) ? 16'hFFFF : disc_sum_s[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized bench for instr_prefetch_buffer: a transaction-level model (instruction queue,
// expected fetch PC, in-flight/doomed fetch tracking) is compared against the DUT every cycle.
module tb_instr_prefetch_buffer;
  localparam int ADDR_W  = 25;
  localparam int PC_W    = 24;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               mem_rd_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_ack;
  logic               mem_rd_valid;
  logic [15:0]        mem_rd_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
`ifdef PREFETCH_STATS_EN
  logic [15:0]        stat_fetched;
  logic [15:0]        stat_discarded;
`endif

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .ADDR_W(ADDR_W), .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(24'h000000)
  ) dut (
    .sys_clock(clk), .reset_n(reset_n),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef PREFETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_discarded(stat_discarded)
`endif
  );

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] data;
  } entry_t;

  int errors = 0;
  int checks = 0;

  // model state
  entry_t            q[$];
  logic [PC_W-1:0]   exp_pc;
  bit                inflight, doomed, lo_seen, held_prev;
  logic [15:0]       lo_val;
  logic [ADDR_W-1:0] held_addr;
  int                start_cnt;
  logic [ADDR_W-1:0] last_start_addr;
  logic [ADDR_W-1:0] req_log[$];
  int unsigned       mdl_fetched, mdl_disc;

  // memory responder state
  int                ack_cnt;
  bit                outstanding;
  logic [ADDR_W-1:0] out_addr;
  int                lat_cnt;
  int                ack_min, ack_max, lat_min, lat_max;
  bit                data_rand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] haddr(input logic [PC_W-1:0] pc, input logic hi);
    return {pc, hi};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_pc = 24'h000000; inflight = 0; doomed = 0; lo_seen = 0; held_prev = 0;
    lo_val = 16'h0000; held_addr = '0; mdl_fetched = 0; mdl_disc = 0;
    ack_cnt = -1; outstanding = 0; out_addr = '0; lat_cnt = 0;
  endtask

  // One clock: compare at negedge, drive memory/fetch inputs, advance the model to the next posedge
  task automatic cycle(input bit rdy, input bit redir, input logic [PC_W-1:0] rpc);
    bit     fresh, push;
    entry_t pe;
    @(negedge clk);
    check("instr_valid", instr_valid, 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("instr_data", instr_data, q[0].data);
      check("instr_pc", instr_pc, q[0].pc);
    end
`ifdef PREFETCH_STATS_EN
    check("stat_fetched", stat_fetched, 64'((mdl_fetched > 65535) ? 65535 : mdl_fetched));
    check("stat_discarded", stat_discarded, 64'((mdl_disc > 65535) ? 65535 : mdl_disc));
`endif
    if (mem_rd_req) check("one_outstanding", outstanding, 0);

    mem_rd_ack = 1'b0;
    mem_rd_valid = 1'b0;
    if (outstanding) begin
      if (lat_cnt == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = data_rand ? 16'($urandom) : (out_addr[0] ? 16'h2222 : 16'h1111);
        outstanding  = 0;
      end else lat_cnt--;
    end else if (mem_rd_req) begin
      if (ack_cnt < 0) ack_cnt = $urandom_range(ack_max, ack_min);
      if (ack_cnt == 0) begin
        mem_rd_ack = 1'b1; outstanding = 1; out_addr = mem_addr;
        lat_cnt = $urandom_range(lat_max, lat_min); ack_cnt = -1;
      end else ack_cnt--;
    end
    instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;

    if (held_prev) begin
      check("req_held", mem_rd_req, 1);
      check("addr_held", mem_addr, held_addr);
    end
    fresh = mem_rd_req && !held_prev;
    if (fresh && !inflight) begin
      check("lo_addr", mem_addr, haddr(exp_pc, 1'b0));
      check("space_reserved", 64'(q.size() < DEPTH), 1);
      inflight = 1; lo_seen = 0; start_cnt++; last_start_addr = mem_addr;
    end else if (fresh) begin
      check("hi_addr", mem_addr, haddr(exp_pc, 1'b1));
      check("hi_after_lo", lo_seen, 1);
    end
    if (fresh) req_log.push_back(mem_addr);
    held_prev = mem_rd_req && !mem_rd_ack;
    held_addr = mem_addr;

    push = 0;
    if (redir) mdl_disc += q.size() + ((inflight && !doomed) ? 1 : 0);
    if (mem_rd_valid) begin
      if (doomed || redir) begin
        inflight = 0; doomed = 0;
      end else if (!lo_seen) begin
        lo_val = mem_rd_data; lo_seen = 1;
      end else begin
        push = 1; pe.pc = exp_pc; pe.data = {mem_rd_data, lo_val}; inflight = 0;
      end
    end
    if (redir && inflight) doomed = 1;
    if (redir) begin
      q.delete();
      exp_pc = rpc;
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (push) begin
        q.push_back(pe); mdl_fetched++; exp_pc = exp_pc + 24'h000001;
      end
    end
  endtask

  task automatic wait_start(input bit rdy, input string tag);
    int sc = start_cnt;
    int n = 0;
    while (start_cnt == sc && n < 300) begin
      cycle(rdy, 1'b0, 24'h000000);
      n++;
    end
    check({tag, "_start_seen"}, 64'(start_cnt != sc), 1);
  endtask

  initial begin
    int n;
    int pct;
    reset_n = 1'b0; mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 16'h0000;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 24'h000000;
    model_reset(); start_cnt = 0; last_start_addr = '0;
    ack_min = 0; ack_max = 0; lat_min = 1; lat_max = 1; data_rand = 0;

    #12;
    check("rst_req", mem_rd_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_pc", instr_pc, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // fill with fixed halfwords, nothing consumed
    repeat (80) cycle(1'b0, 1'b0, 24'h000000);
    check("p1_req_count", req_log.size(), 8);
    for (int i = 0; i < 8 && i < req_log.size(); i++) check("p1_addr_seq", req_log[i], 64'(i));
    check("p1_valid", instr_valid, 1);
    check("p1_head_data", instr_data, 32'h22221111);
    check("p1_head_pc", instr_pc, 0);
    check("p1_stopped", mem_rd_req, 0);

    // pop one: exactly one more instruction (pc 4)
    cycle(1'b1, 1'b0, 24'h000000);
    repeat (40) cycle(1'b0, 1'b0, 24'h000000);
    check("p2_req_count", req_log.size(), 10);
    if (req_log.size() >= 10) begin
      check("p2_addr_lo", req_log[8], 25'h0000008);
      check("p2_addr_hi", req_log[9], 25'h0000009);
    end
    check("p2_head_pc", instr_pc, 24'h000001);
    check("p2_full", q.size(), 4);

    // redirect to 0x40 while the high half of pc 2 is outstanding
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b1, 24'h000000);
    n = 0;
    while (!(outstanding && out_addr == 25'h0000005) && n < 200) begin
      cycle(1'b0, 1'b0, 24'h000000); n++;
    end
    check("p3_wait_hi_reached", 64'(n < 200), 1);
    cycle(1'b0, 1'b1, 24'h000040);
    wait_start(1'b0, "p3");
    check("p3_next_addr", last_start_addr, 25'h0000080);
    n = 0;
    while (!instr_valid && n < 200) begin
      cycle(1'b0, 1'b0, 24'h000000); n++;
    end
    check("p3_first_pc", instr_pc, 24'h000040);

    // redirect while a low request is held off by the memory
    ack_min = 3; ack_max = 3; lat_min = 1; lat_max = 1;
    wait_start(1'b1, "p4a");
    cycle(1'b1, 1'b1, 24'h000100);
    cycle(1'b1, 1'b0, 24'h000000);
    check("p4_flushed", instr_valid, 0);
    wait_start(1'b1, "p4b");
    check("p4_next_addr", last_start_addr, 25'h0000200);

    // redirect plus pop with three queued entries
    ack_min = 0; ack_max = 0; lat_min = 0; lat_max = 0;
    cycle(1'b0, 1'b1, 24'h000200);
    n = 0;
    while (q.size() != 3 && n < 200) begin
      cycle(1'b0, 1'b0, 24'h000000); n++;
    end
    check("p5_three_entries", q.size(), 3);
    cycle(1'b1, 1'b1, 24'h000300);
    n = start_cnt;
    cycle(1'b0, 1'b0, 24'h000000);
    check("p5_valid_dropped", instr_valid, 0);
    if (start_cnt == n) wait_start(1'b0, "p5");
    check("p5_next_addr", last_start_addr, 25'h0000600);

    // PC wrap
    ack_min = 0; ack_max = 1; lat_min = 0; lat_max = 1;
    cycle(1'b1, 1'b1, 24'hFFFFFF);
    wait_start(1'b1, "p6a");
    check("p6_top_addr", last_start_addr, 25'h1FFFFFE);
    wait_start(1'b1, "p6b");
    check("p6_wrap_addr", last_start_addr, 25'h0000000);

    // random traffic
    data_rand = 1; ack_min = 0; ack_max = 3; lat_min = 0; lat_max = 3;
    pct = 70;
    for (int c = 0; c < 3000; c++) begin
      logic [PC_W-1:0] rpc;
      if (c % 500 == 0) pct = $urandom_range(95, 5);
      rpc = 24'($urandom);
      if ($urandom_range(3, 0) == 0) rpc = 24'hFFFFFE | 24'($urandom_range(1, 0));
      cycle($urandom_range(99, 0) < pct, $urandom_range(39, 0) == 0, rpc);
    end

    // asynchronous reset mid-operation, then a stray late valid in IDLE
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req", mem_rd_req, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_data", instr_data, 0);
    check("mid_rst_pc", instr_pc, 0);
    model_reset();
    mem_rd_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD;
    for (int c = 0; c < 400; c++)
      cycle($urandom_range(1, 0) == 1, $urandom_range(29, 0) == 0, 24'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
